imem_loader: RTL and testbench



---
 rtl/my_pkg.sv | 24 ++
 rtl/imem_load_counter.sv | 48 ++++
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
// Shared control-path types: fetch-stage source select, loader states and loader limits.
package my_pkg;

    typedef enum logic [1:0] {
        NOP       = 2'd0,
        IMEM      = 2'd1,
        FSM_RSVD2 = 2'd2,
        FSM_RSVD3 = 2'd3
    } FSM_Control_Enum;

    typedef enum logic [2:0] {
        L_IDLE = 3'd0,
        L_LEN  = 3'd1,
        L_LOAD = 3'd2,
        L_CHK  = 3'd3,
        L_RUN  = 3'd4,
        L_ERR  = 3'd5
    } Loader_State_Enum;

    localparam int unsigned IMEM_LOAD_MAX_WORDS = 1024;
    localparam int unsigned IMEM_DATA_W         = 32;
    localparam int unsigned IMEM_ADDR_W         = 10;

endpackage

// File: rtl/imem_load_counter.sv
// Word counter, length register and running modulo-2^32 checksum for the program loader.
module imem_load_counter
    import my_pkg::*;
#(
    parameter int unsigned CNT_W = IMEM_ADDR_W + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic                   clr_i,
    input  logic                   len_ld_i,
    input  logic                   step_i,
    input  logic [CNT_W-1:0]       len_i,
    input  logic [IMEM_DATA_W-1:0] data_i,
    output logic [CNT_W-1:0]       count_o,
    output logic                   last_c,
    output logic [IMEM_DATA_W-1:0] sum_o
);

    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       len_q;
    logic [IMEM_DATA_W-1:0] sum_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            len_q   <= '0;
            sum_q   <= '0;
        end else if (en_i) begin
            if (len_ld_i) begin
                len_q <= len_i;
            end
            if (clr_i) begin
                count_q <= '0;
                sum_q   <= '0;
            end else if (step_i) begin
                count_q <= count_q + CNT_W'(1);
                sum_q   <= sum_q + data_i;
            end
        end
    end

    // Only meaningful while loading, where len_q is at least 1.
    assign last_c  = (count_q == (len_q - CNT_W'(1)));
    assign count_o = count_q;
    assign sum_o   = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory writer: takes a length-prefixed, checksummed word stream and
// hands the fetch stage over to IMEM only once the checksum matches.
module imem_loader
    import my_pkg::*;
#(
    parameter int unsigned ADDR_W    = IMEM_ADDR_W,
    parameter int unsigned MAX_WORDS = IMEM_LOAD_MAX_WORDS
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic              START,
    input  logic              S_VALID,
    input  logic [31:0]       S_DATA,
    output logic              S_READY,
    output logic              IMEM_WE,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [31:0]       IMEM_DIN,
    output FSM_Control_Enum   FSM_SEL,
    output logic              CORE_EN,
    output logic              DONE,
    output logic              ERR
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    Loader_State_Enum  state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    FSM_Control_Enum   sel_q;
    logic              core_en_q;
    logic              done_q;
    logic              err_q;

    logic              hs;
    logic              len_bad;
    logic              len_ok_hs;
    logic              load_hs;
    logic [CNT_W-1:0]  count;
    logic              last;
    logic [31:0]       sum;

    assign S_READY   = EN & ((state_q == L_LEN) | (state_q == L_LOAD) | (state_q == L_CHK));
    assign hs        = S_VALID & S_READY;
    assign len_bad   = (S_DATA == 32'd0) || (S_DATA > 32'(MAX_WORDS));
    assign len_ok_hs = hs & (state_q == L_LEN) & ~len_bad;
    assign load_hs   = hs & (state_q == L_LOAD);

    imem_load_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i    (CLK),
        .rst_n_i  (RSTn),
        .en_i     (EN),
        .clr_i    (len_ok_hs),
        .len_ld_i (len_ok_hs),
        .step_i   (load_hs),
        .len_i    (S_DATA[ADDR_W:0]),
        .data_i   (S_DATA),
        .count_o  (count),
        .last_c   (last),
        .sum_o    (sum)
    );

    // Control FSM; status outputs are updated on the same edge as the state change.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= L_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            sel_q     <= NOP;
            core_en_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (!EN) begin
            we_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                L_IDLE: begin
                    if (START) begin
                        state_q <= L_LEN;
                    end
                end
                L_LEN: begin
                    if (hs) begin
                        if (len_bad) begin
                            state_q <= L_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= L_LOAD;
                        end
                    end
                end
                L_LOAD: begin
                    if (hs) begin
                        we_q   <= 1'b1;
                        addr_q <= ADDR_W'(count);
                        din_q  <= S_DATA;
                        if (last) begin
                            state_q <= L_CHK;
                        end
                    end
                end
                L_CHK: begin
                    if (hs) begin
                        if (S_DATA == sum) begin
                            state_q   <= L_RUN;
                            sel_q     <= IMEM;
                            core_en_q <= 1'b1;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= L_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                L_RUN: begin
                    if (START) begin
                        state_q   <= L_LEN;
                        sel_q     <= NOP;
                        core_en_q <= 1'b0;
                        done_q    <= 1'b0;
                    end
                end
                L_ERR: begin
                    if (START) begin
                        state_q <= L_LEN;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= L_IDLE;
                end
            endcase
        end
    end

    assign IMEM_WE   = we_q;
    assign IMEM_ADDR = addr_q;
    assign IMEM_DIN  = din_q;
    assign FSM_SEL   = sel_q;
    assign CORE_EN   = core_en_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: protocol-level model compared every cycle, plus literal spot checks.
module tb_imem_loader;
    import my_pkg::*;

    localparam int unsigned AW   = 10;
    localparam int unsigned MAXW = 1024;

    logic            clk = 1'b0;
    logic            rstn;
    logic            en;
    logic            start;
    logic            s_valid;
    logic [31:0]     s_data;
    logic            s_ready;
    logic            imem_we;
    logic [AW-1:0]   imem_addr;
    logic [31:0]     imem_din;
    FSM_Control_Enum fsm_sel;
    logic            core_en;
    logic            done;
    logic            err;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(AW), .MAX_WORDS(MAXW)) dut (
        .CLK       (clk),
        .RSTn      (rstn),
        .EN        (en),
        .START     (start),
        .S_VALID   (s_valid),
        .S_DATA    (s_data),
        .S_READY   (s_ready),
        .IMEM_WE   (imem_we),
        .IMEM_ADDR (imem_addr),
        .IMEM_DIN  (imem_din),
        .FSM_SEL   (fsm_sel),
        .CORE_EN   (core_en),
        .DONE      (done),
        .ERR       (err)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory image as seen by the fetch stage, and a count of write pulses.
    logic [31:0] mem [0:MAXW-1];
    int          we_pulses = 0;
    always @(posedge clk) begin
        if (imem_we === 1'b1) begin
            mem[imem_addr] <= imem_din;
            we_pulses      <= we_pulses + 1;
        end
    end

    // Protocol-level model: a phase, how many words are promised/received, and their sum.
    typedef enum {M_IDLE, M_LEN, M_LOAD, M_CHK, M_RUN, M_ERR} phase_t;
    phase_t      m_phase = M_IDLE;
    int          m_len   = 0;
    int          m_cnt   = 0;
    logic [31:0] m_sum   = '0;
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_din   = '0;
    bit          m_ok    = 1'b0;

    initial begin
        logic        l_rst, l_en, l_start, l_valid, l_hs, accepting;
        logic [31:0] l_data;
        forever begin
            @(negedge clk);
            accepting = (m_phase == M_LEN) || (m_phase == M_LOAD) || (m_phase == M_CHK);
            if (m_ok) begin
                check("s_ready",   32'(s_ready),   32'(en && accepting));
                check("imem_we",   32'(imem_we),   32'(m_we));
                check("imem_addr", 32'(imem_addr), m_addr);
                check("imem_din",  imem_din,       m_din);
                check("fsm_sel",   32'(fsm_sel),   (m_phase == M_RUN) ? 32'(IMEM) : 32'(NOP));
                check("core_en",   32'(core_en),   32'(m_phase == M_RUN));
                check("done",      32'(done),      32'(m_phase == M_RUN));
                check("err",       32'(err),       32'(m_phase == M_ERR));
            end
            l_rst   = rstn;
            l_en    = en;
            l_start = start;
            l_valid = s_valid;
            l_data  = s_data;
            l_hs    = l_en && l_valid && accepting;
            @(posedge clk);
            if (!l_rst) begin
                m_phase = M_IDLE;
                m_len   = 0;
                m_cnt   = 0;
                m_sum   = '0;
                m_we    = 1'b0;
                m_addr  = '0;
                m_din   = '0;
                m_ok    = 1'b1;
            end else if (m_ok) begin
                m_we = 1'b0;
                if (l_en) begin
                    case (m_phase)
                        M_IDLE: if (l_start) m_phase = M_LEN;
                        M_LEN: if (l_hs) begin
                            if (l_data == 32'd0 || l_data > MAXW) begin
                                m_phase = M_ERR;
                            end else begin
                                m_len   = int'(l_data);
                                m_cnt   = 0;
                                m_sum   = '0;
                                m_phase = M_LOAD;
                            end
                        end
                        M_LOAD: if (l_hs) begin
                            m_we   = 1'b1;
                            m_addr = 32'(m_cnt);
                            m_din  = l_data;
                            m_sum  = m_sum + l_data;
                            m_cnt++;
                            if (m_cnt == m_len) m_phase = M_CHK;
                        end
                        M_CHK: if (l_hs) m_phase = (l_data == m_sum) ? M_RUN : M_ERR;
                        default: if (l_start) m_phase = M_LEN;
                    endcase
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Present one word and hold it until it is accepted, with a bounded wait.
    task automatic send(input logic [31:0] d);
        bit hs;
        bit taken;
        taken   = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 200 && !taken; i++) begin
            @(negedge clk);
            hs = s_ready && en;
            @(posedge clk);
            #2;
            if (hs) taken = 1'b1;
        end
        s_valid = 1'b0;
        if (!taken) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: word 0x%08h not accepted within 200 cycles", d);
        end
    endtask

    task automatic load(input logic [31:0] w[$], input logic [31:0] ck);
        send(32'(w.size()));
        foreach (w[i]) send(w[i]);
        send(ck);
    endtask

    function automatic logic [31:0] csum(input logic [31:0] w[$]);
        logic [31:0] s;
        s = '0;
        foreach (w[i]) s = s + w[i];
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] q[$];
        int          p;
        rstn    = 1'b0;
        en      = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        tick(2);
        rstn = 1'b1;
        check("rst_sel",   32'(fsm_sel), 32'(NOP));
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_done",  32'(done),    32'd0);
        tick(1);

        // Test 1: three-word program, checksum 0x13+0x100093+0x208113 = 0x003081B9.
        q.delete();
        q.push_back(32'h00000013);
        q.push_back(32'h00100093);
        q.push_back(32'h00208113);
        pulse_start();
        load(q, 32'h003081B9);
        check("t1_done",    32'(done),    32'd1);
        check("t1_sel",     32'(fsm_sel), 32'(IMEM));
        check("t1_core_en", 32'(core_en), 32'd1);
        check("t1_mem0",    mem[0],       32'h00000013);
        check("t1_mem1",    mem[1],       32'h00100093);
        check("t1_mem2",    mem[2],       32'h00208113);
        tick(1);

        // Test 2: same program, checksum off by one.
        pulse_start();
        load(q, 32'h003081BA);
        check("t2_err",     32'(err),     32'd1);
        check("t2_sel",     32'(fsm_sel), 32'(NOP));
        check("t2_core_en", 32'(core_en), 32'd0);
        tick(1);

        // Test 3: zero length, oversize length, then a one-word load.
        p = we_pulses;
        pulse_start();
        send(32'd0);
        tick(1);
        check("t3_err_len0", 32'(err), 32'd1);
        pulse_start();
        send(32'd1025);
        tick(1);
        check("t3_err_len1025", 32'(err), 32'd1);
        check("t3_no_we",       32'(we_pulses), 32'(p));
        q.delete();
        q.push_back(32'hDEADBEEF);
        pulse_start();
        load(q, csum(q));
        check("t3_done", 32'(done), 32'd1);
        check("t3_mem0", mem[0],    32'hDEADBEEF);
        tick(1);

        // Test 4: gapped valid and a three-cycle enable stall mid-load.
        pulse_start();
        send(32'd4);
        s_valid = 1'b0; tick(1);
        send(32'h11111111);
        s_valid = 1'b0; tick(1);
        send(32'h22222222);
        en      = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h33333333;
        tick(3);
        en = 1'b1;
        send(32'h33333333);
        s_valid = 1'b0; tick(1);
        send(32'h44444444);
        s_valid = 1'b0; tick(1);
        send(32'hAAAAAAAA);
        check("t4_done", 32'(done), 32'd1);
        check("t4_mem0", mem[0], 32'h11111111);
        check("t4_mem1", mem[1], 32'h22222222);
        check("t4_mem2", mem[2], 32'h33333333);
        check("t4_mem3", mem[3], 32'h44444444);
        tick(1);

        // Test 5: reset after the second data word, then a clean reload.
        pulse_start();
        send(32'd3);
        send(32'h00000013);
        send(32'h00100093);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        check("t5_we",    32'(imem_we),   32'd0);
        check("t5_addr",  32'(imem_addr), 32'd0);
        check("t5_din",   imem_din,       32'd0);
        check("t5_ready", 32'(s_ready),   32'd0);
        check("t5_done",  32'(done),      32'd0);
        check("t5_err",   32'(err),       32'd0);
        q.delete();
        q.push_back(32'h00000013);
        q.push_back(32'h00100093);
        q.push_back(32'h00208113);
        pulse_start();
        load(q, 32'h003081B9);
        check("t5_run", 32'(done), 32'd1);
        tick(1);

        // Test 6: restart from RUN, then a full-size program.
        pulse_start();
        check("t6_sel_nop",  32'(fsm_sel), 32'(NOP));
        check("t6_core_off", 32'(core_en), 32'd0);
        q.delete();
        for (int i = 0; i < int'(MAXW); i++) q.push_back({16'(i), ~16'(i)});
        load(q, csum(q));
        check("t6_done",    32'(done),    32'd1);
        check("t6_sel",     32'(fsm_sel), 32'(IMEM));
        check("t6_mem0",    mem[0],       32'h0000FFFF);
        check("t6_mem1023", mem[1023],    32'h03FFFC00);
        for (int i = 0; i < int'(MAXW); i++) begin
            if (mem[i] !== q[i]) check("t6_mem", mem[i], q[i]);
        end
        check("t6_we_total_ok", 32'(imem_we), 32'd0);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
